param_loader_mc: RTL



---
 rtl/param_loader_mc_if.sv | 39 +++
 rtl/param_loader_mc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/param_loader_mc_if.sv
// param_loader_mc_if
//   Bundles the pad-side beat bus and the core-side handshake of the
//   multi-coefficient parameter loader. clk and rst_n are not part of it.
//
//   pin_data   [PIN_W]            beat payload, source -> loader
//   pin_valid                     beat present, source -> loader
//   pin_ready                     loader can take a beat, loader -> source
//   load_abort                    discard a partial load, source -> loader
//   coef       [NUM_COEF*COEF_W]  committed coefficients, loader -> core
//   start_calc                    level request to the core, loader -> core
//   core_busy                     core running, core -> loader
//   chk_err                       sticky checksum failure, loader -> system
//
//   master: the side that drives beats and the core_busy response (bench/system)
//   slave : the loader itself
interface param_loader_mc_if #(
  parameter int NUM_COEF = 2,
  parameter int PIN_W    = 8,
  parameter int COEF_W   = 32
);
  logic [PIN_W-1:0]           pin_data;
  logic                       pin_valid;
  logic                       pin_ready;
  logic                       load_abort;
  logic [NUM_COEF*COEF_W-1:0] coef;
  logic                       start_calc;
  logic                       core_busy;
  logic                       chk_err;

  modport master (
    output pin_data, pin_valid, load_abort, core_busy,
    input  pin_ready, coef, start_calc, chk_err
  );

  modport slave (
    input  pin_data, pin_valid, load_abort, core_busy,
    output pin_ready, coef, start_calc, chk_err
  );
endinterface

// File: rtl/param_loader_mc.sv
// param_loader_mc
//   Assembles NUM_COEF coefficients from a narrow beat-serial pin bus
//   (valid/ready), LSB beat first, LOAD_BEATS beats per coefficient. A
//   complete set is sign- or zero-extended and committed to the coefficient
//   bus on a single edge, after which a level handshake (start_calc /
//   core_busy) hands control to the calculation core.
//
//   Optional feature: define PARAM_LOADER_CHKSUM_EN to expect one extra beat
//   after the data beats holding the XOR of all data beats. A mismatch
//   suppresses the commit and the core start and raises the sticky chk_err,
//   which clears on the first beat of the next load. Without the macro there
//   is no checksum beat and chk_err is tied low.
//
// Ports
//   clk    clock
//   rst_n  asynchronous, active-low reset
//   bus    param_loader_mc_if.slave (pin bus, coef, start_calc/core_busy, chk_err)
//
// Parameters
//   NUM_COEF   coefficients per set (1..16)
//   PIN_W      pin bus width
//   COEF_W     coefficient width, multiple of PIN_W
//   LOAD_BEATS beats per coefficient (1..COEF_W/PIN_W)
//   SIGNED     1: sign-extend from bit LOAD_BEATS*PIN_W-1, 0: zero-extend
//
// States
//   IDLE   | waiting for the first beat of a set; pin_ready high
//   LOAD   | collecting the remaining beats; pin_ready high
//   COMMIT | one cycle: publish the shadow set (or flag checksum error)
//   START  | start_calc high until core_busy is seen high
//   RUN    | core running; wait for core_busy low
module param_loader_mc #(
  parameter int NUM_COEF   = 2,
  parameter int PIN_W      = 8,
  parameter int COEF_W     = 32,
  parameter int LOAD_BEATS = 1,
  parameter int SIGNED     = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  param_loader_mc_if.slave bus
);

  localparam int LW   = LOAD_BEATS * PIN_W;
  localparam int CC_W = (NUM_COEF > 1) ? $clog2(NUM_COEF) : 1;
  localparam int BC_W = (LOAD_BEATS > 1) ? $clog2(LOAD_BEATS) : 1;

  localparam logic [CC_W-1:0]   LAST_COEF = CC_W'(NUM_COEF - 1);
  localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(LOAD_BEATS - 1);
  // Bits above the loaded width; empty when a coefficient is loaded in full.
  localparam logic [COEF_W-1:0] EXT_MASK  = {COEF_W{1'b1}} << LW;

  typedef enum logic [2:0] {IDLE, LOAD, COMMIT, START, RUN} state_t;

  state_t                     state;
  state_t                     state_next;

  logic [BC_W-1:0]            beat_cnt;
  logic [CC_W-1:0]            coef_cnt;
  logic [NUM_COEF-1:0][LW-1:0] shadow;
  logic [NUM_COEF*COEF_W-1:0] coef_ext;
  logic [NUM_COEF*COEF_W-1:0] coef_q;
  logic                       start_q;

  logic pin_ready;
  logic beat_acc;
  logic abort;
  logic last_data;
  logic data_beat;
  logic load_done;
  logic commit_ok;

  // pin_ready is a pure state decode so the source sees it combinationally.
  assign pin_ready = (state == IDLE) || (state == LOAD);
  assign beat_acc  = bus.pin_valid && pin_ready;
  // Abort only has an effect while loading; it is ignored once a set is complete.
  assign abort     = bus.load_abort && pin_ready;
  // Counters sit at 0/0 in IDLE, so a one-beat set is complete on its first beat.
  assign last_data = (beat_cnt == LAST_BEAT) && (coef_cnt == LAST_COEF);

`ifdef PARAM_LOADER_CHKSUM_EN
  logic             chk_phase;   // next accepted beat is the checksum beat
  logic             chk_bad;
  logic             chk_err_q;
  logic [PIN_W-1:0] xor_acc;

  assign data_beat = beat_acc && !abort && !chk_phase;
  assign load_done = beat_acc && !abort && chk_phase;
  assign commit_ok = !chk_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_phase <= 1'b0;
      chk_bad   <= 1'b0;
      chk_err_q <= 1'b0;
      xor_acc   <= '0;
    end else begin
      if (abort) begin
        chk_phase <= 1'b0;
        xor_acc   <= '0;
      end else if (beat_acc) begin
        if (chk_phase) begin
          chk_bad   <= (bus.pin_data != xor_acc);
          chk_phase <= 1'b0;
        end else begin
          // The first beat of a set restarts the running XOR.
          xor_acc <= (state == IDLE) ? bus.pin_data : (xor_acc ^ bus.pin_data);
          if (last_data) begin
            chk_phase <= 1'b1;
          end
        end
        if (state == IDLE) begin
          chk_err_q <= 1'b0;
        end
      end
      if ((state == COMMIT) && chk_bad) begin
        chk_err_q <= 1'b1;
      end
    end
  end

  assign bus.chk_err = chk_err_q;
`else
  assign data_beat   = beat_acc && !abort;
  assign load_done   = data_beat && last_data;
  assign commit_ok   = 1'b1;
  assign bus.chk_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, LOAD: begin
        if (abort) begin
          state_next = IDLE;
        end else if (load_done) begin
          state_next = COMMIT;
        end else if (beat_acc) begin
          state_next = LOAD;
        end
      end
      COMMIT: state_next = commit_ok ? START : IDLE;
      START:  if (bus.core_busy)  state_next = RUN;
      RUN:    if (!bus.core_busy) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    coef_ext = '0;
    for (int c = 0; c < NUM_COEF; c++) begin
      coef_ext[c*COEF_W +: COEF_W] = COEF_W'(shadow[c]);
      if ((SIGNED != 0) && shadow[c][LW-1]) begin
        coef_ext[c*COEF_W +: COEF_W] = coef_ext[c*COEF_W +: COEF_W] | EXT_MASK;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      beat_cnt <= '0;
      coef_cnt <= '0;
      shadow   <= '0;
      coef_q   <= '0;
      start_q  <= 1'b0;
    end else begin
      // Registered copy of "in START" so start_calc is glitch-free.
      start_q <= (state_next == START);

      if (abort) begin
        beat_cnt <= '0;
        coef_cnt <= '0;
        shadow   <= '0;
      end else if (data_beat) begin
        for (int c = 0; c < NUM_COEF; c++) begin
          for (int b = 0; b < LOAD_BEATS; b++) begin
            if ((coef_cnt == CC_W'(c)) && (beat_cnt == BC_W'(b))) begin
              shadow[c][b*PIN_W +: PIN_W] <= bus.pin_data;
            end
          end
        end
        // Both counters wrap to 0 after the last data beat, ready for the next set.
        if (beat_cnt == LAST_BEAT) begin
          beat_cnt <= '0;
          coef_cnt <= (coef_cnt == LAST_COEF) ? '0 : coef_cnt + 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end

      if ((state == COMMIT) && commit_ok) begin
        coef_q <= coef_ext;
      end
    end
  end

  assign bus.pin_ready  = pin_ready;
  assign bus.coef       = coef_q;
  assign bus.start_calc = start_q;

endmodule
